// File: rtl/id_stage_pipe_pkg.sv
// id_stage_pipe_pkg: opcode/funct constants, ALU codes and the instruction decoder shared by the ID stage.
package id_stage_pipe_pkg;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_ANDI = 6'b001100, OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI = 6'b001111, OP_SPECIAL = 6'b000000, OP_LW = 6'b100011;
  localparam logic [5:0] FN_AND = 6'b100100, FN_OR = 6'b100101, FN_XOR = 6'b100110, FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLL = 6'b000000, FN_SRL = 6'b000010, FN_SRA = 6'b000011;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic [4:0] NOP_REG_ADDR = 5'h0;
  typedef enum logic [7:0] {
    ALU_NOP = 8'h00, ALU_AND = 8'h24, ALU_OR = 8'h25, ALU_XOR = 8'h26, ALU_NOR = 8'h27,
    ALU_SLL = 8'h7c, ALU_SRL = 8'h02, ALU_SRA = 8'h03, ALU_LW = 8'he3
  } aluop_e;
  typedef enum logic [2:0] {SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_LOAD = 3'd3} alusel_e;
  typedef struct packed {
    logic        valid;
    logic        re1;
    logic        re2;
    logic [4:0]  wd;
    aluop_e      aluop;
    alusel_e     alusel;
    logic [31:0] imm;
  } dec_t;
  // imm doubles as the reg1 operand for shifts (sa) and the reg2 operand for I-type
  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    d = '{valid: 1'b0, re1: 1'b0, re2: 1'b0, wd: NOP_REG_ADDR, aluop: ALU_NOP, alusel: SEL_NOP, imm: ZERO_WORD};
    case (inst[31:26])
      OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
        d.valid  = 1'b1;
        d.re1    = 1'b1;
        d.wd     = inst[20:16];
        d.alusel = SEL_LOGIC;
        d.aluop  = inst[31:26] == OP_ANDI ? ALU_AND : inst[31:26] == OP_XORI ? ALU_XOR : ALU_OR;
        d.imm    = inst[31:26] == OP_LUI ? {inst[15:0], 16'h0} : {16'h0, inst[15:0]};
      end
      OP_LW: begin
        d.valid  = 1'b1;
        d.re1    = 1'b1;
        d.wd     = inst[20:16];
        d.alusel = SEL_LOAD;
        d.aluop  = ALU_LW;
        d.imm    = {{16{inst[15]}}, inst[15:0]};
      end
      OP_SPECIAL: begin
        case (inst[5:0])
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            d.valid  = 1'b1;
            d.re1    = 1'b1;
            d.re2    = 1'b1;
            d.wd     = inst[15:11];
            d.alusel = SEL_LOGIC;
            d.aluop  = inst[5:0] == FN_AND ? ALU_AND : inst[5:0] == FN_OR ? ALU_OR :
                       inst[5:0] == FN_XOR ? ALU_XOR : ALU_NOR;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            d.valid  = 1'b1;
            d.re2    = 1'b1;
            d.wd     = inst[15:11];
            d.alusel = SEL_SHIFT;
            d.aluop  = inst[5:0] == FN_SLL ? ALU_SLL : inst[5:0] == FN_SRL ? ALU_SRL : ALU_SRA;
            d.imm    = {27'h0, inst[10:6]};
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/id_stage_pipe_operand_mux.sv
// id_operand_mux: one source-operand port; immediate, $0, EX bypass, MEM bypass, then register file.
module id_operand_mux
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              re,
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_wreg,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_wreg,
  input  logic [REG_AW-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] data
);
  assign data = !re ? imm :
                addr == '0 ? DATA_W'(ZERO_WORD) :
                ex_wreg && ex_wd == addr ? ex_wdata :
                mem_wreg && mem_wd == addr ? mem_wdata : rf_data;
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS ID stage; decode, operand bypass, load-use stall detect and the ID/EX register.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   pc_i,
  input  logic [31:0]         inst_i,
  input  logic                inst_valid_i,
  input  logic [DATA_W-1:0]   reg1_data_i,
  input  logic [DATA_W-1:0]   reg2_data_i,
  output logic                reg1_read_o,
  output logic                reg2_read_o,
  output logic [REG_AW-1:0]   reg1_addr_o,
  output logic [REG_AW-1:0]   reg2_addr_o,
  input  logic                ex_wreg_i,
  input  logic [REG_AW-1:0]   ex_wd_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic                ex_is_load_i,
  input  logic                mem_wreg_i,
  input  logic [REG_AW-1:0]   mem_wd_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic                stall_i,
  input  logic                flush_i,
  output logic                stall_req_o,
  output logic [ALUOP_W-1:0]  ex_aluop_o,
  output logic [ALUSEL_W-1:0] ex_alusel_o,
  output logic [DATA_W-1:0]   ex_reg1_o,
  output logic [DATA_W-1:0]   ex_reg2_o,
  output logic [REG_AW-1:0]   ex_wd_o,
  output logic                ex_wreg_o,
  output logic [DATA_W-1:0]   ex_pc_o,
  output logic                ex_valid_o,
  output logic                invalid_inst_o
);
  dec_t              d;
  logic [DATA_W-1:0] imm, op1, op2;
  logic              take, load, bad;
  assign d           = decode(inst_i);
  assign imm         = DATA_W'(d.imm);
  assign reg1_read_o = d.re1;
  assign reg2_read_o = d.re2;
  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);
  assign stall_req_o = inst_valid_i & ex_is_load_i & ex_wreg_i & (ex_wd_i != '0) &
                       ((d.re1 & (reg1_addr_o == ex_wd_i)) | (d.re2 & (reg2_addr_o == ex_wd_i)));
  assign take = !flush_i && !stall_req_o && inst_valid_i;
  assign load = take && d.valid;
  assign bad  = take && !d.valid;
  id_operand_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_mux1 (
    .re(d.re1), .addr(reg1_addr_o), .imm(imm), .rf_data(reg1_data_i),
    .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i),
    .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i), .data(op1)
  );
  id_operand_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_mux2 (
    .re(d.re2), .addr(reg2_addr_o), .imm(imm), .rf_data(reg2_data_i),
    .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i),
    .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i), .data(op2)
  );
  // flush overrides a downstream hold; anything not loaded becomes a bubble
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid_o     <= 1'b0;
      ex_aluop_o     <= ALUOP_W'(ALU_NOP);
      ex_alusel_o    <= ALUSEL_W'(SEL_NOP);
      ex_reg1_o      <= '0;
      ex_reg2_o      <= '0;
      ex_wd_o        <= '0;
      ex_wreg_o      <= 1'b0;
      ex_pc_o        <= '0;
      invalid_inst_o <= 1'b0;
    end else if (flush_i || !stall_i) begin
      ex_valid_o     <= load;
      ex_aluop_o     <= load ? ALUOP_W'(d.aluop) : ALUOP_W'(ALU_NOP);
      ex_alusel_o    <= load ? ALUSEL_W'(d.alusel) : ALUSEL_W'(SEL_NOP);
      ex_reg1_o      <= load ? op1 : '0;
      ex_reg2_o      <= load ? op2 : '0;
      ex_wd_o        <= load ? REG_AW'(d.wd) : '0;
      ex_wreg_o      <= load && d.wd != NOP_REG_ADDR;
      ex_pc_o        <= pc_i;
      invalid_inst_o <= bad;
    end else begin
      invalid_inst_o <= 1'b0;
    end
  end
endmodule
